apb_master_nslv: RTL and testbench
==================================

APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

Interface
REQ-001 SHALL have parameter NUM_SLV, default 6, number of APB slave ports; legal range 1..16.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1000_0000, base of the peripheral window; bits [15:0] are ignored.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, ACCESS-phase wait limit in cycles; legal range 2..255.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 PCLK  in  1  clock; all state updates on rising edge.
REQ-006 PRESET  in  1  asynchronous active-high reset.
REQ-007 transfer  in  1  CPU request strobe; sampled in IDLE only.
REQ-008 write  in  1  1 = write, 0 = read.
REQ-009 addr  in  32  CPU byte address.
REQ-010 wdata  in  32  CPU write data.
REQ-011 rdata  out  32  read data; valid only while ready=1.
REQ-012 ready  out  1  transfer-complete pulse, one cycle.
REQ-013 err  out  1  error qualifier; valid only while ready=1.
REQ-014 PADDR  out  32  latched address.
REQ-015 PWDATA  out  32  latched write data.
REQ-016 PWRITE  out  1  latched direction.
REQ-017 PENABLE  out  1  APB enable.
REQ-018 PSEL  out  NUM_SLV  one-hot slave select.
REQ-019 PRDATA  in  32*NUM_SLV  packed read data; slave i occupies bits [32*i+31:32*i].
REQ-020 PREADY  in  NUM_SLV  per-slave ready.

Function
REQ-021 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-022 IDLE: PSEL=0, PENABLE=0; on transfer=1, latch addr, wdata and write into PADDR, PWDATA and PWRITE, then go to SETUP.
REQ-023 Decode: hit when addr[31:16]==BASE_ADDR[31:16] and addr[15:12]<NUM_SLV; slave index = addr[15:12]; decoded at latch time and held for the whole transfer.
REQ-024 SETUP: PSEL[idx]=1 on a hit, else all PSEL=0; PENABLE=0; next state is ACCESS unconditionally.
REQ-025 ACCESS: PENABLE=1, PSEL unchanged; when PREADY[idx]=1, drive ready=1 combinationally in that cycle, with rdata=PRDATA[idx] and err=0; next state is IDLE.
REQ-026 Decode miss: no PSEL asserted; complete in the first ACCESS cycle with ready=1, err=1, rdata=0.
REQ-027 PREADY of unselected slaves SHALL be ignored.
REQ-028 Outside a completing ACCESS cycle: ready=0, err=0, rdata=0.
REQ-029 transfer asserted in SETUP or ACCESS SHALL be ignored; minimum transfer cost is 3 cycles including IDLE.
REQ-030 PADDR, PWDATA and PWRITE SHALL stay stable from SETUP through the end of ACCESS.

Reset
REQ-031 PRESET=1 SHALL immediately force state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, ready=0, err=0, and wait counter 0.
REQ-032 Reset mid-transfer SHALL abort the transfer with no ready pulse; the first request after reset release starts from IDLE.

Configuration
REQ-033 Macro APB_MASTER_NSLV_TIMEOUT_EN defined: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without PREADY[idx].
REQ-034 With the macro, when the count reaches TIMEOUT_CYC-1 with PREADY still low, the block SHALL drive ready=1, err=1, rdata=0, and next state IDLE (PSEL and PENABLE drop).
REQ-035 Without the macro: no counter; ACCESS waits indefinitely for PREADY[idx]; err is asserted only on decode miss.

Verification
REQ-036 Write hit: addr=32'h1000_2004, wdata=32'hA5, write=1, PREADY[2]=1 immediately -> PSEL=6'b000100 in SETUP and ACCESS, PENABLE=1 only in ACCESS, ready=1 and err=0 in the 3rd cycle after the request.
REQ-037 Read with wait: addr=32'h1000_4000, PREADY[4] high after 3 ACCESS cycles, PRDATA[4]=32'h0000_00F0 -> ready=1, rdata=32'hF0 in that cycle, PADDR stable throughout.
REQ-038 Decode miss: addr=32'h1000_7000 with NUM_SLV=6 -> PSEL=0 for the whole transfer, ready=1, err=1, rdata=0 in the first ACCESS cycle.
REQ-039 Timeout (macro defined, TIMEOUT_CYC=4): PREADY held low -> ready=1, err=1 in the 4th ACCESS cycle, then IDLE; without the macro, PSEL/PENABLE still held after 100 cycles.
REQ-040 Reset mid-ACCESS: PRESET=1 pulsed asynchronously -> PSEL and PENABLE go to 0 with no clock edge, no ready pulse; a new transfer after reset completes normally.
REQ-041 Ignored request and isolation: transfer held high during ACCESS while an unselected PREADY[0]=1 -> no early completion and exactly one ready per accepted request.

Source files
------------

// File: rtl/apb_master_nslv.sv
// APB master bridging a single CPU request port to NUM_SLV APB slaves (IDLE/SETUP/ACCESS).
// Optional ACCESS wait-limit enabled by defining APB_MASTER_NSLV_TIMEOUT_EN.
module apb_master_nslv #(
  parameter int unsigned NUM_SLV     = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    transfer,
  input  logic                    write,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic                    err,
  output logic [31:0]             PADDR,
  output logic [31:0]             PWDATA,
  output logic                    PWRITE,
  output logic                    PENABLE,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [32*NUM_SLV-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        hit_q, hit_d;
  logic [3:0]  idx_q, idx_d;

  logic               addr_hit;
  logic [NUM_SLV-1:0] sel_onehot;
  logic               sel_ready;
  logic [31:0]        sel_rdata;
  logic               timeout;
  logic               done;

  assign addr_hit = (addr[31:16] == BASE_ADDR[31:16]) && (32'(addr[15:12]) < NUM_SLV);

  // Slave selection is computed from the index latched at request time, so
  // PREADY/PRDATA of every other slave never reach the completion logic.
  always_comb begin
    sel_onehot = '0;
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (hit_q && (idx_q == 4'(i))) begin
        sel_onehot[i] = 1'b1;
        sel_ready     = PREADY[i];
        sel_rdata     = PRDATA[32*i +: 32];
      end
    end
  end

`ifdef APB_MASTER_NSLV_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !sel_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout = (state_q == ACCESS) && hit_q && !sel_ready &&
                   (wait_cnt_q == 8'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  assign done = (state_q == ACCESS) && (!hit_q || sel_ready || timeout);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (transfer) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PSEL    = '0;
    PENABLE = 1'b0;
    ready   = 1'b0;
    err     = 1'b0;
    rdata   = '0;
    case (state_q)
      SETUP: begin
        PSEL = sel_onehot;
      end
      ACCESS: begin
        PSEL    = sel_onehot;
        PENABLE = 1'b1;
        ready   = done;
        err     = done && (!hit_q || timeout);
        if (done && hit_q && sel_ready) begin
          rdata = sel_rdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    hit_d    = hit_q;
    idx_d    = idx_q;
    if ((state_q == IDLE) && transfer) begin
      paddr_d  = addr;
      pwdata_d = wdata;
      pwrite_d = write;
      hit_d    = addr_hit;
      idx_d    = addr[15:12];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      hit_q    <= hit_d;
      idx_q    <= idx_d;
    end
  end

  assign PADDR  = paddr_q;
  assign PWDATA = pwdata_q;
  assign PWRITE = pwrite_q;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Directed + randomized bench for apb_master_nslv with a transaction-level expectation model.
module tb_apb_master_nslv;

  localparam int unsigned NS = 6;
  localparam int unsigned TO = 4;
`ifdef APB_MASTER_NSLV_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              PCLK;
  logic              PRESET;
  logic              transfer;
  logic              write;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic [31:0]       PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic              PENABLE;
  logic [NS-1:0]     PSEL;
  logic [32*NS-1:0]  PRDATA;
  logic [NS-1:0]     PREADY;

  int checks = 0;
  int errors = 0;

  apb_master_nslv #(
    .NUM_SLV    (NS),
    .BASE_ADDR  (32'h1000_0000),
    .TIMEOUT_CYC(TO)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_psel"},  32'(PSEL),    32'd0);
    chk({tag, "_pen"},   32'(PENABLE), 32'd0);
    chk({tag, "_ready"}, 32'(ready),   32'd0);
    chk({tag, "_err"},   32'(err),     32'd0);
    chk({tag, "_rdata"}, rdata,        32'd0);
  endtask

  // One CPU request, started just after a negedge while the master is idle.
  // wt = ACCESS cycles the selected slave holds PREADY low before raising it.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic w,
                      input int unsigned wt, input logic hold,
                      input logic fix, input logic [31:0] fixv);
    logic          hit;
    int unsigned   idx;
    int unsigned   k;
    logic          e_err;
    logic [NS-1:0] esel;
    logic [31:0]   erd;
    hit  = (a[31:16] == 16'h1000) && (32'(a[15:12]) < NS);
    idx  = 32'(a[15:12]);
    esel = '0;
    if (hit) esel[idx] = 1'b1;
    if (!hit) begin
      k = 1; e_err = 1'b1;
    end else if (TO_EN && (wt >= TO)) begin
      k = TO; e_err = 1'b1;
    end else begin
      k = wt + 1; e_err = 1'b0;
    end

    transfer = 1'b1; write = w; addr = a; wdata = wd;
    PREADY = NS'($urandom());
    #1;
    chk_idle("idle");

    @(negedge PCLK);
    transfer = hold; addr = $urandom(); wdata = $urandom(); write = ~w;
    #1;
    chk("setup_psel",   32'(PSEL),    32'(esel));
    chk("setup_pen",    32'(PENABLE), 32'd0);
    chk("setup_ready",  32'(ready),   32'd0);
    chk("setup_paddr",  PADDR,        a);
    chk("setup_pwdata", PWDATA,       wd);
    chk("setup_pwrite", 32'(PWRITE),  32'(w));

    for (int unsigned j = 1; j <= k; j++) begin
      @(negedge PCLK);
      for (int unsigned i = 0; i < NS; i++) PRDATA[32*i +: 32] = fix ? fixv : $urandom();
      PREADY = NS'($urandom());
      if (hold) PREADY[0] = 1'b1;
      if (hit) PREADY[idx] = (j > wt);
      erd = ((j == k) && hit && !e_err) ? PRDATA[32*idx +: 32] : 32'd0;
      #1;
      chk("acc_psel",   32'(PSEL),    32'(esel));
      chk("acc_pen",    32'(PENABLE), 32'd1);
      chk("acc_paddr",  PADDR,        a);
      chk("acc_pwdata", PWDATA,       wd);
      chk("acc_pwrite", 32'(PWRITE),  32'(w));
      chk("acc_ready",  32'(ready),   32'(j == k));
      chk("acc_err",    32'(err),     32'((j == k) && e_err));
      chk("acc_rdata",  rdata,        erd);
    end
    @(negedge PCLK);
    transfer = 1'b0;
    PREADY   = '0;
  endtask

  initial begin
    PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    PRDATA = '0; PREADY = '0;
    #1;
    chk_idle("rst");
    chk("rst_paddr",  PADDR,       32'd0);
    chk("rst_pwdata", PWDATA,      32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);

    // write hit to slave 2, immediate PREADY
    xfer(32'h1000_2004, 32'h0000_00A5, 1'b1, 0, 1'b0, 1'b0, 32'd0);
    // read from slave 4 with three wait cycles
    xfer(32'h1000_4000, 32'h1234_5678, 1'b0, 3, 1'b0, 1'b1, 32'h0000_00F0);
    // decode miss: index 7 beyond NUM_SLV, and a foreign window
    xfer(32'h1000_7000, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 1'b0, 32'd0);
    xfer(32'h2000_1000, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b0, 32'd0);
    // long wait: times out with the limit enabled, else held for 100 cycles
    xfer(32'h1000_5000, 32'h0BAD_F00D, 1'b0, 100, 1'b0, 1'b0, 32'd0);
    // transfer held high during ACCESS with unselected PREADY[0] asserted
    xfer(32'h1000_3008, 32'h5555_AAAA, 1'b0, 2, 1'b1, 1'b0, 32'd0);
    chk_idle("after_hold");

    // asynchronous reset in the middle of ACCESS
    transfer = 1'b1; write = 1'b1; addr = 32'h1000_1010; wdata = 32'hCAFE_0001;
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    PREADY = '0;
    #1;
    chk("mid_pen",  32'(PENABLE), 32'd1);
    chk("mid_psel", 32'(PSEL),    32'h2);
    #1 PRESET = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst_paddr", PADDR, 32'd0);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    #1;
    chk_idle("post_rst");
    xfer(32'h1000_1010, 32'hCAFE_0002, 1'b1, 1, 1'b0, 1'b0, 32'd0);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] ra;
      ra = {($urandom_range(0, 3) == 0) ? 16'h2000 : 16'h1000,
            4'($urandom_range(0, 15)), 12'($urandom())};
      xfer(ra, $urandom(), 1'($urandom()), $urandom_range(0, 6),
           1'($urandom()), 1'b0, 32'd0);
    end
    #1;
    chk_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
